tap_controller: RTL and testbench

- IEEE 1149.1-style TAP controller that sequences the boundary-scan register chain.
- Contains the 16-state TAP FSM, a 4-bit instruction register, and the BYPASS and IDCODE data registers.
- Generates the CAPTURE/SHIFT/UPDATE/ENABLE and mode strobes consumed by the boundary-scan register, and muxes all scan paths onto TDO.
- Sits between the chip-level JTAG pins and the boundary-scan register.

---
 rtl/tap_controller_if.sv | 49 ++++
 rtl/tap_controller.sv | 196 +++++++++++++++++++
 tb/tb_tap_controller.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_controller_if.sv
// tap_controller_if: JTAG pin-side and boundary-scan-side signals of the TAP controller.
//   master : drives TMS/TDI/BSR_TDO and observes everything else (pin driver / bench)
//   slave  : the TAP controller itself
// Signals:
//   TMS, TDI          - JTAG mode select and serial data in
//   BSR_TDO           - serial out of the boundary-scan chain
//   TDO, TDO_EN       - serial data out and its enable (Shift-IR/Shift-DR only)
//   CAPTURE/SHIFT/UPDATE, ENABLE, MODE_*      - boundary-scan register controls
//   CAPTURE/UPDATE_MODE_INPUT/OUTPUT          - per-cell-class qualifiers
//   STATE, IR         - current TAP state and active instruction
interface tap_controller_if #(
  parameter int unsigned IR_WIDTH = 4
);
  logic                TMS;
  logic                TDI;
  logic                BSR_TDO;
  logic                TDO;
  logic                TDO_EN;
  logic                CAPTURE;
  logic                SHIFT;
  logic                UPDATE;
  logic                ENABLE;
  logic                MODE_TEST_NORMAL;
  logic                MODE_SHIFT_LOAD;
  logic                CAPTURE_MODE_INPUT;
  logic                UPDATE_MODE_INPUT;
  logic                CAPTURE_MODE_OUTPUT;
  logic                UPDATE_MODE_OUTPUT;
  logic [3:0]          STATE;
  logic [IR_WIDTH-1:0] IR;

  modport master (
    output TMS, TDI, BSR_TDO,
    input  TDO, TDO_EN, CAPTURE, SHIFT, UPDATE, ENABLE,
           MODE_TEST_NORMAL, MODE_SHIFT_LOAD,
           CAPTURE_MODE_INPUT, UPDATE_MODE_INPUT,
           CAPTURE_MODE_OUTPUT, UPDATE_MODE_OUTPUT,
           STATE, IR
  );

  modport slave (
    input  TMS, TDI, BSR_TDO,
    output TDO, TDO_EN, CAPTURE, SHIFT, UPDATE, ENABLE,
           MODE_TEST_NORMAL, MODE_SHIFT_LOAD,
           CAPTURE_MODE_INPUT, UPDATE_MODE_INPUT,
           CAPTURE_MODE_OUTPUT, UPDATE_MODE_OUTPUT,
           STATE, IR
  );
endinterface

// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1-style TAP controller.
// 16-state TAP FSM, IR_WIDTH-bit instruction register, BYPASS and IDCODE data
// registers, boundary-scan strobe/mode generation and the TDO mux.
// Ports:
//   TCK   - sole clock, all state updates on its rising edge
//   RESET - synchronous active-high, forces Test-Logic-Reset
//   bus   - tap_controller_if.slave (JTAG pins + boundary-scan controls)
module tap_controller #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1234_5071,
  parameter logic [IR_WIDTH-1:0] OPC_EXTEST   = IR_WIDTH'(4'b0000),
  parameter logic [IR_WIDTH-1:0] OPC_SAMPLE   = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] OPC_IDCODE   = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0] OPC_INTEST   = IR_WIDTH'(4'b0011)
) (
  input  logic             TCK,
  input  logic             RESET,
  tap_controller_if.slave  bus
);

  localparam int unsigned ID_WIDTH = 32;

  // Standard 1149.1 state encoding
  typedef enum logic [3:0] {
    S_EXIT2_DR   = 4'h0,
    S_EXIT1_DR   = 4'h1,
    S_SHIFT_DR   = 4'h2,
    S_PAUSE_DR   = 4'h3,
    S_SELECT_IR  = 4'h4,
    S_UPDATE_DR  = 4'h5,
    S_CAPTURE_DR = 4'h6,
    S_SELECT_DR  = 4'h7,
    S_EXIT2_IR   = 4'h8,
    S_EXIT1_IR   = 4'h9,
    S_SHIFT_IR   = 4'hA,
    S_PAUSE_IR   = 4'hB,
    S_RTI        = 4'hC,
    S_UPDATE_IR  = 4'hD,
    S_CAPTURE_IR = 4'hE,
    S_TLR        = 4'hF
  } tap_state_e;

  tap_state_e            r_state;
  tap_state_e            w_next_state;
  logic [IR_WIDTH-1:0]   r_ir;
  logic [IR_WIDTH-1:0]   r_ir_shift;
  logic [ID_WIDTH-1:0]   r_id_shift;
  logic                  r_bypass;

  logic w_capture;
  logic w_shift;
  logic w_update;
  logic w_tdo;
  logic w_tdo_en;
  logic w_sel_bsr;
  logic w_sel_id;
  logic w_cap_in;
  logic w_upd_in;
  logic w_cap_out;
  logic w_upd_out;
  logic w_test_normal;

  // TAP state register; RESET overrides TMS
  always_ff @(posedge TCK) begin
    if (RESET) r_state <= S_TLR;
    else       r_state <= w_next_state;
  end

  // Next-state, DR strobes and TDO mux, all decoded from the current state
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_shift      = 1'b0;
    w_update     = 1'b0;
    w_tdo        = 1'b0;
    w_tdo_en     = 1'b0;
    case (r_state)
      S_TLR:        w_next_state = bus.TMS ? S_TLR       : S_RTI;
      S_RTI:        w_next_state = bus.TMS ? S_SELECT_DR : S_RTI;
      S_SELECT_DR:  w_next_state = bus.TMS ? S_SELECT_IR : S_CAPTURE_DR;
      S_CAPTURE_DR: begin
        w_next_state = bus.TMS ? S_EXIT1_DR : S_SHIFT_DR;
        w_capture    = 1'b1;
      end
      S_SHIFT_DR: begin
        w_next_state = bus.TMS ? S_EXIT1_DR : S_SHIFT_DR;
        w_shift      = 1'b1;
        w_tdo_en     = 1'b1;
        if (w_sel_bsr)     w_tdo = bus.BSR_TDO;
        else if (w_sel_id) w_tdo = r_id_shift[0];
        else               w_tdo = r_bypass;
      end
      S_EXIT1_DR:   w_next_state = bus.TMS ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:   w_next_state = bus.TMS ? S_EXIT2_DR  : S_PAUSE_DR;
      S_EXIT2_DR:   w_next_state = bus.TMS ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR: begin
        w_next_state = bus.TMS ? S_SELECT_DR : S_RTI;
        w_update     = 1'b1;
      end
      S_SELECT_IR:  w_next_state = bus.TMS ? S_TLR       : S_CAPTURE_IR;
      S_CAPTURE_IR: w_next_state = bus.TMS ? S_EXIT1_IR  : S_SHIFT_IR;
      S_SHIFT_IR: begin
        w_next_state = bus.TMS ? S_EXIT1_IR : S_SHIFT_IR;
        w_tdo        = r_ir_shift[0];
        w_tdo_en     = 1'b1;
      end
      S_EXIT1_IR:   w_next_state = bus.TMS ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:   w_next_state = bus.TMS ? S_EXIT2_IR  : S_PAUSE_IR;
      S_EXIT2_IR:   w_next_state = bus.TMS ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR:  w_next_state = bus.TMS ? S_SELECT_DR : S_RTI;
      default:      w_next_state = S_TLR;
    endcase
  end

  // Instruction decode; undefined and all-ones opcodes fall through to BYPASS
  always_comb begin
    w_sel_bsr     = 1'b0;
    w_sel_id      = 1'b0;
    w_cap_in      = 1'b0;
    w_upd_in      = 1'b0;
    w_cap_out     = 1'b0;
    w_upd_out     = 1'b0;
    w_test_normal = 1'b0;
    if (r_ir == OPC_EXTEST) begin
      w_sel_bsr     = 1'b1;
      w_cap_in      = 1'b1;
      w_upd_out     = 1'b1;
      w_test_normal = 1'b1;
    end else if (r_ir == OPC_INTEST) begin
      w_sel_bsr     = 1'b1;
      w_upd_in      = 1'b1;
      w_cap_out     = 1'b1;
      w_test_normal = 1'b1;
    end else if (r_ir == OPC_SAMPLE) begin
      w_sel_bsr     = 1'b1;
      w_cap_in      = 1'b1;
      w_upd_in      = 1'b1;
      w_cap_out     = 1'b1;
      w_upd_out     = 1'b1;
    end else if (r_ir == OPC_IDCODE) begin
      w_sel_id      = 1'b1;
    end
  end

  // Instruction path; TLR keeps reloading IDCODE so partial shifts are discarded
  always_ff @(posedge TCK) begin
    if (RESET) begin
      r_ir       <= OPC_IDCODE;
      r_ir_shift <= '0;
    end else begin
      case (r_state)
        S_TLR:        r_ir       <= OPC_IDCODE;
        S_CAPTURE_IR: r_ir_shift <= IR_WIDTH'(1);
        S_SHIFT_IR:   r_ir_shift <= {bus.TDI, r_ir_shift[IR_WIDTH-1:1]};
        S_UPDATE_IR:  r_ir       <= r_ir_shift;
        default:      ;
      endcase
    end
  end

  // IDCODE and BYPASS data registers; pause/exit states hold contents
  always_ff @(posedge TCK) begin
    if (RESET) begin
      r_id_shift <= '0;
      r_bypass   <= 1'b0;
    end else begin
      case (r_state)
        S_CAPTURE_DR: begin
          r_id_shift <= IDCODE_VALUE;
          r_bypass   <= 1'b0;
        end
        S_SHIFT_DR: begin
          r_id_shift <= {bus.TDI, r_id_shift[ID_WIDTH-1:1]};
          r_bypass   <= bus.TDI;
        end
        default: ;
      endcase
    end
  end

  assign bus.TDO                 = w_tdo;
  assign bus.TDO_EN              = w_tdo_en;
  assign bus.CAPTURE             = w_capture;
  assign bus.SHIFT               = w_shift;
  assign bus.UPDATE              = w_update;
  assign bus.MODE_SHIFT_LOAD     = w_shift;
  assign bus.ENABLE              = w_sel_bsr;
  assign bus.MODE_TEST_NORMAL    = w_test_normal;
  assign bus.CAPTURE_MODE_INPUT  = w_cap_in;
  assign bus.UPDATE_MODE_INPUT   = w_upd_in;
  assign bus.CAPTURE_MODE_OUTPUT = w_cap_out;
  assign bus.UPDATE_MODE_OUTPUT  = w_upd_out;
  assign bus.STATE               = r_state;
  assign bus.IR                  = r_ir;

endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed bench for tap_controller.
module tb_tap_controller;

  logic tck;
  logic reset;
  int   checks;
  int   errors;

  tap_controller_if #(.IR_WIDTH(4)) bus ();

  tap_controller #(.IR_WIDTH(4)) dut (
    .TCK   (tck),
    .RESET (reset),
    .bus   (bus.slave)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // One TCK cycle: drive TMS/TDI, let the rising edge take them, settle 1 time unit
  task automatic tick(input logic tms, input logic tdi);
    bus.TMS = tms;
    bus.TDI = tdi;
    @(posedge tck);
    #1;
  endtask

  // RTI -> Shift-DR
  task automatic goto_shdr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI, load an instruction and return to RTI, collecting the IR TDO stream
  task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = bus.TDO;
      tick(i == 3, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    checks++;
    if (bus.STATE !== 4'hF) begin errors++; $display("FAIL reset_state got %h exp F", bus.STATE); end
    checks++;
    if (bus.IR !== 4'b0010) begin errors++; $display("FAIL reset_ir got %b exp 0010", bus.IR); end
    checks++;
    if ({bus.CAPTURE, bus.SHIFT, bus.UPDATE, bus.ENABLE, bus.MODE_TEST_NORMAL} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 00000",
               {bus.CAPTURE, bus.SHIFT, bus.UPDATE, bus.ENABLE, bus.MODE_TEST_NORMAL});
    end
    checks++;
    if ({bus.TDO, bus.TDO_EN} !== 2'b00) begin
      errors++; $display("FAIL reset_tdo got %b exp 00", {bus.TDO, bus.TDO_EN});
    end
  endtask

  task automatic test_reset_mid_shift();
    logic upd_seen;
    tick(1'b0, 1'b0);
    goto_shdr();
    checks++;
    if (bus.STATE !== 4'h2) begin errors++; $display("FAIL mid_shdr_state got %h exp 2", bus.STATE); end
    reset = 1'b1;
    tick(1'b0, 1'b1);
    reset = 1'b0;
    upd_seen = bus.UPDATE;
    checks++;
    if (bus.STATE !== 4'hF) begin errors++; $display("FAIL mid_reset_state got %h exp F", bus.STATE); end
    checks++;
    if (bus.IR !== 4'b0010) begin errors++; $display("FAIL mid_reset_ir got %b exp 0010", bus.IR); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      upd_seen = upd_seen | bus.UPDATE;
    end
    checks++;
    if (upd_seen !== 1'b0) begin errors++; $display("FAIL mid_reset_update got %b exp 0", upd_seen); end
    // Partial IR shift interrupted by reset: IR must stay IDCODE
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b1);
    reset = 1'b0;
    checks++;
    if (bus.IR !== 4'b0010) begin errors++; $display("FAIL mid_ir_reset_ir got %b exp 0010", bus.IR); end
  endtask

  task automatic test_tms_reset();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (bus.STATE !== 4'hA) begin errors++; $display("FAIL shir_state got %h exp A", bus.STATE); end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    checks++;
    if (bus.STATE !== 4'hF) begin errors++; $display("FAIL tms5_state got %h exp F", bus.STATE); end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_idcode();
    logic [31:0] stream;
    int          en_cnt;
    goto_shdr();
    en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      stream[i] = bus.TDO;
      if (bus.TDO_EN === 1'b1) en_cnt++;
      tick(i == 31, 1'b0);
    end
    if (bus.TDO_EN === 1'b1) en_cnt++;
    checks++;
    if (stream !== 32'h1234_5071) begin errors++; $display("FAIL idcode_stream got %h exp 12345071", stream); end
    checks++;
    if (en_cnt !== 32) begin errors++; $display("FAIL idcode_tdo_en got %0d exp 32", en_cnt); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_ir_bypass();
    logic [3:0] cap;
    logic [2:0] obs;
    logic [2:0] din;
    load_ir(4'b1111, cap);
    checks++;
    if (cap !== 4'b0001) begin errors++; $display("FAIL ir_capture got %b exp 0001", cap); end
    checks++;
    if (bus.IR !== 4'b1111) begin errors++; $display("FAIL ir_load got %b exp 1111", bus.IR); end
    din = 3'b101;
    goto_shdr();
    for (int i = 0; i < 3; i++) begin
      obs[i] = bus.TDO;
      tick(i == 2, din[i]);
    end
    checks++;
    if (obs !== 3'b010) begin errors++; $display("FAIL bypass_delay got %b exp 010", obs); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_extest();
    logic [3:0] cap;
    logic [3:0] pat;
    int         shift_cnt;
    int         tdo_bad;
    load_ir(4'b0000, cap);
    checks++;
    if ({bus.ENABLE, bus.MODE_TEST_NORMAL, bus.CAPTURE_MODE_INPUT, bus.UPDATE_MODE_INPUT,
         bus.CAPTURE_MODE_OUTPUT, bus.UPDATE_MODE_OUTPUT} !== 6'b111001) begin
      errors++;
      $display("FAIL extest_modes got %b exp 111001",
               {bus.ENABLE, bus.MODE_TEST_NORMAL, bus.CAPTURE_MODE_INPUT, bus.UPDATE_MODE_INPUT,
                bus.CAPTURE_MODE_OUTPUT, bus.UPDATE_MODE_OUTPUT});
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if ({bus.CAPTURE, bus.SHIFT, bus.UPDATE} !== 3'b100) begin
      errors++; $display("FAIL extest_capture got %b exp 100", {bus.CAPTURE, bus.SHIFT, bus.UPDATE});
    end
    tick(1'b0, 1'b0);
    pat       = 4'b1011;
    shift_cnt = 0;
    tdo_bad   = 0;
    for (int i = 0; i < 4; i++) begin
      bus.BSR_TDO = pat[i];
      #1;
      if ({bus.CAPTURE, bus.SHIFT, bus.UPDATE, bus.MODE_SHIFT_LOAD} === 4'b0101) shift_cnt++;
      if (bus.TDO !== pat[i]) tdo_bad++;
      tick(i == 3, 1'b0);
    end
    if (bus.SHIFT === 1'b1) shift_cnt++;
    checks++;
    if (shift_cnt !== 4) begin errors++; $display("FAIL extest_shift_cycles got %0d exp 4", shift_cnt); end
    checks++;
    if (tdo_bad !== 0) begin errors++; $display("FAIL extest_bsr_tdo got %0d bad exp 0", tdo_bad); end
    tick(1'b1, 1'b0);
    checks++;
    if ({bus.CAPTURE, bus.SHIFT, bus.UPDATE} !== 3'b001) begin
      errors++; $display("FAIL extest_update got %b exp 001", {bus.CAPTURE, bus.SHIFT, bus.UPDATE});
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({bus.CAPTURE, bus.SHIFT, bus.UPDATE} !== 3'b000) begin
      errors++; $display("FAIL extest_rti got %b exp 000", {bus.CAPTURE, bus.SHIFT, bus.UPDATE});
    end
  endtask

  task automatic test_sample_pause();
    logic [3:0] cap;
    int         pause_bad;
    load_ir(4'b0001, cap);
    checks++;
    if ({bus.ENABLE, bus.MODE_TEST_NORMAL, bus.CAPTURE_MODE_INPUT, bus.UPDATE_MODE_INPUT,
         bus.CAPTURE_MODE_OUTPUT, bus.UPDATE_MODE_OUTPUT} !== 6'b101111) begin
      errors++;
      $display("FAIL sample_modes got %b exp 101111",
               {bus.ENABLE, bus.MODE_TEST_NORMAL, bus.CAPTURE_MODE_INPUT, bus.UPDATE_MODE_INPUT,
                bus.CAPTURE_MODE_OUTPUT, bus.UPDATE_MODE_OUTPUT});
    end
    goto_shdr();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    pause_bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.STATE !== 4'h3 || bus.SHIFT !== 1'b0 || bus.TDO_EN !== 1'b0) pause_bad++;
      tick(k == 2, 1'b0);
    end
    checks++;
    if (pause_bad !== 0) begin errors++; $display("FAIL sample_pause got %0d bad exp 0", pause_bad); end
    tick(1'b0, 1'b0);
    bus.BSR_TDO = 1'b1;
    #1;
    checks++;
    if ({bus.STATE, bus.SHIFT, bus.TDO_EN, bus.TDO} !== 7'b0010_111) begin
      errors++; $display("FAIL sample_resume got %b exp 0010111", {bus.STATE, bus.SHIFT, bus.TDO_EN, bus.TDO});
    end
    bus.BSR_TDO = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_idcode_pause();
    logic [3:0]  cap;
    logic [31:0] stream;
    load_ir(4'b0010, cap);
    goto_shdr();
    for (int i = 0; i < 32; i++) begin
      stream[i] = bus.TDO;
      tick(i == 7 || i == 31, 1'b0);
      if (i == 7) begin
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end
    end
    checks++;
    if (stream !== 32'h1234_5071) begin errors++; $display("FAIL idcode_pause_stream got %h exp 12345071", stream); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_undefined();
    logic [3:0] cap;
    logic [2:0] obs;
    logic [2:0] din;
    load_ir(4'b0110, cap);
    checks++;
    if (bus.IR !== 4'b0110) begin errors++; $display("FAIL undef_ir got %b exp 0110", bus.IR); end
    checks++;
    if ({bus.ENABLE, bus.MODE_TEST_NORMAL, bus.CAPTURE_MODE_INPUT, bus.UPDATE_MODE_INPUT,
         bus.CAPTURE_MODE_OUTPUT, bus.UPDATE_MODE_OUTPUT} !== 6'b000000) begin
      errors++;
      $display("FAIL undef_modes got %b exp 000000",
               {bus.ENABLE, bus.MODE_TEST_NORMAL, bus.CAPTURE_MODE_INPUT, bus.UPDATE_MODE_INPUT,
                bus.CAPTURE_MODE_OUTPUT, bus.UPDATE_MODE_OUTPUT});
    end
    din = 3'b011;
    bus.BSR_TDO = 1'b1;
    goto_shdr();
    for (int i = 0; i < 3; i++) begin
      obs[i] = bus.TDO;
      tick(i == 2, din[i]);
    end
    bus.BSR_TDO = 1'b0;
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL undef_bypass got %b exp 110", obs); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    // Entering TLR via TMS restores IDCODE
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    checks++;
    if (bus.IR !== 4'b0010) begin errors++; $display("FAIL tlr_reload_ir got %b exp 0010", bus.IR); end
    tick(1'b0, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.TMS     = 1'b1;
    bus.TDI     = 1'b0;
    bus.BSR_TDO = 1'b0;
    test_reset();
    test_reset_mid_shift();
    test_tms_reset();
    test_idcode();
    test_ir_bypass();
    test_extest();
    test_sample_pause();
    test_idcode_pause();
    test_undefined();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
